exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
- MEM-stage exception controller, directly upstream of cp0.
- Collects per-instruction exception flags and pending interrupts, applies fixed priority, and waits for any outstanding data-bus transaction to finish.
- Then issues one registered exception pulse: excepttype, EPC source, delay-slot flag, bad address.
- Drives pipeline flush and redirect PC, including ERET return to EPC with forwarding of an in-flight mtc0 EPC write.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for all exceptions except ERET.
- FLUSH_CYCLES, 1, cycles flush_o stays high after issue (1..4).
- SYNC_STAGES, 2, flop depth of the int_i synchronizer (2..3).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset; 0 = reset.
- int_i  in  6  asynchronous hardware interrupt lines.
- int_sync_o  out  6  synchronized interrupts, to cp0 int_i.
- valid_i  in  1  MEM stage holds a real instruction.
- pc_i  in  32  MEM instruction address.
- is_in_delayslot_i  in  1  MEM instruction is in a delay slot.
- adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_ls_i, ades_i, eret_i  in  1 each  exception flags.
- bad_data_addr_i  in  32  load/store effective address.
- status_i, cause_i, epc_i  in  32 each  current cp0 registers.
- cp0_we_i  in  1  WB-stage mtc0 write enable.
- cp0_waddr_i  in  5  WB-stage mtc0 address.
- cp0_wdata_i  in  32  WB-stage mtc0 data.
- bus_busy_i  in  1  data bus has an outstanding transaction.
- excepttype_o  out  32  to cp0.
- current_inst_addr_o  out  32  to cp0.
- is_in_delayslot_o  out  1  to cp0.
- bad_addr_o  out  32  to cp0.
- stall_req_o  out  1  freezes IF..MEM.
- flush_o  out  1  flushes all pipeline registers.
- new_pc_o  out  32  redirect target, valid while flush_o=1.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; synchronizer flops 0; latched exception info 0.
- Effective CP0 values:
  - eff_status = (cp0_we_i && waddr==12) ? cp0_wdata_i : status_i.
  - eff_epc uses waddr==14 the same way.
  - eff_cause uses cause_i with bits [9:8] replaced by cp0_wdata_i[9:8] when waddr==13.
- Interrupt pending: valid_i && eff_status[0] && !eff_status[1] && |(eff_status[15:8] & eff_cause[15:8]).
- Priority, highest first, with code:
  - interrupt 0x1
  - adel_if 0x4, bad_addr=pc_i
  - ri 0xa
  - ov 0xc
  - trap 0xd
  - syscall 0x8
  - break 0x9
  - adel_ls 0x4, bad_addr=bad_data_addr_i
  - ades 0x5, bad_addr=bad_data_addr_i
  - eret 0xe
- Flags are ignored when valid_i=0.
- Exception code is 0 when nothing is pending; bad_addr is 0 for codes without an address.
- States:
  - IDLE:
    - Exception pending and bus_busy_i=0: register outputs and go ISSUE.
    - Exception pending and bus_busy_i=1: latch code, pc, delay-slot flag, bad_addr and eff_epc; go WAIT_BUS.
    - stall_req_o is asserted combinationally in the detection cycle in both cases.
  - WAIT_BUS:
    - stall_req_o=1.
    - New flags and interrupts are ignored; latched info is held.
    - Go ISSUE on the first cycle with bus_busy_i=0.
  - ISSUE (exactly 1 cycle):
    - excepttype_o, current_inst_addr_o, is_in_delayslot_o and bad_addr_o carry the latched values.
    - flush_o=1.
    - new_pc_o = EXC_VECTOR, or the latched eff_epc when code is 0xe.
    - stall_req_o=0.
    - FLUSH_CYCLES==1: go IDLE; otherwise go FLUSH.
  - FLUSH:
    - flush_o=1, new_pc_o held, excepttype_o=0.
    - Counts FLUSH_CYCLES-1 cycles, then goes IDLE.
    - Flags are ignored.
- Latency: exception flag in cycle N with bus idle gives the cp0 pulse and flush_o in cycle N+1.
- excepttype_o is nonzero for exactly one cycle per exception.
- Interrupt synchronizer: SYNC_STAGES-deep flop chain per bit, reset to 0.
- Async reset in any state returns to IDLE immediately; no pending exception survives.

Optional Feature:
- Macro: EXC_CTRL_INT_SYNC_EN.
- Defined: int_sync_o is the SYNC_STAGES-flop synchronized int_i.
- Undefined: int_sync_o = int_i combinationally; SYNC_STAGES is unused.
- Used for simulation/FPGA builds where interrupts already originate in the clk domain.

Decomposition:
- Shared package/defines:
  - exception code constants EXC_INT..EXC_ERET.
  - CP0 register address constants 12/13/14.
  - state encoding IDLE/WAIT_BUS/ISSUE/FLUSH.
  - EXC_VECTOR default.
- Sub-module: exc_int_sync (parameterized SYNC_STAGES, per-bit flop chain, async active-low reset), instantiated under EXC_CTRL_INT_SYNC_EN.

Test Plan:
- ov_i=1, valid_i=1, pc_i=0xBFC00100, bus idle:
  - next cycle excepttype_o=0xC, current_inst_addr_o=0xBFC00100, flush_o=1, new_pc_o=0xBFC00380.
  - one cycle later excepttype_o=0.
- adel_ls_i=1, bad_data_addr_i=0x80000003, bus_busy_i=1 for 3 cycles:
  - stall_req_o high 4 cycles (detect + 3 wait).
  - ISSUE when the bus frees, with code 0x4 and bad_addr_o=0x80000003.
- Simultaneous interrupt and syscall, status=0x0000FF01, cause[10]=1: code 0x1 issued, syscall dropped.
- eret_i=1 with cp0_we_i=1, waddr=14, wdata=0xBFC00200, epc_i=0xBFC00000: new_pc_o=0xBFC00200, code 0xE.
- is_in_delayslot_i=1 with break: is_in_delayslot_o=1 and code 0x9. FLUSH_CYCLES=3 gives flush_o high exactly 3 cycles.
- Reset: rst low mid-WAIT_BUS, then release: all outputs 0, state IDLE, no ISSUE pulse. With EXC_CTRL_INT_SYNC_EN, an int_i edge appears on int_sync_o after 2 clocks.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared constants and types for the MEM-stage exception controller.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TR   = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUS,
        S_ISSUE,
        S_FLUSH
    } exc_state_e;

    typedef struct packed {
        logic [31:0] code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad_addr;
        logic [31:0] epc;
    } exc_info_t;

endpackage

// File: rtl/exc_int_sync.sv
// Per-bit flop-chain synchronizer for the asynchronous interrupt lines.
module exc_int_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d[0] = d_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= sync_d;
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception controller feeding cp0: priority, bus wait, issue pulse, flush/redirect.
// Optional EXC_CTRL_INT_SYNC_EN: synchronize int_i through exc_int_sync; otherwise pass it through.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    output logic [5:0]  int_sync_o,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic        adel_if_i,
    input  logic        ri_i,
    input  logic        ov_i,
    input  logic        trap_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        adel_ls_i,
    input  logic        ades_i,
    input  logic        eret_i,
    input  logic [31:0] bad_data_addr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    input  logic        bus_busy_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        stall_req_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam int FLUSH_INIT = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;

`ifdef EXC_CTRL_INT_SYNC_EN
    exc_int_sync #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(6)) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d_i (int_i),
        .q_o (int_sync_o)
    );
`else
    localparam int UNUSED_SYNC_STAGES = SYNC_STAGES;
    assign int_sync_o = int_i;
`endif

    // Forward a WB-stage mtc0 so the decision sees the value cp0 is about to hold.
    logic [31:0] eff_status, eff_cause, eff_epc;
    always_comb begin
        eff_status = (cp0_we_i && cp0_waddr_i == CP0_STATUS) ? cp0_wdata_i : status_i;
        eff_epc    = (cp0_we_i && cp0_waddr_i == CP0_EPC)    ? cp0_wdata_i : epc_i;
        eff_cause  = cause_i;
        if (cp0_we_i && cp0_waddr_i == CP0_CAUSE) eff_cause[9:8] = cp0_wdata_i[9:8];
    end

    logic unused_bits;
    assign unused_bits = ^{eff_status[31:16], eff_status[7:2], eff_cause[31:16], eff_cause[7:0]};

    logic int_pend;
    assign int_pend = valid_i && eff_status[0] && !eff_status[1] &&
                      |(eff_status[15:8] & eff_cause[15:8]);

    exc_info_t cur;
    always_comb begin
        cur      = '0;
        cur.pc   = pc_i;
        cur.ds   = is_in_delayslot_i;
        cur.epc  = eff_epc;
        if (valid_i) begin
            if (int_pend)       cur.code = EXC_INT;
            else if (adel_if_i) begin cur.code = EXC_ADEL; cur.bad_addr = pc_i; end
            else if (ri_i)      cur.code = EXC_RI;
            else if (ov_i)      cur.code = EXC_OV;
            else if (trap_i)    cur.code = EXC_TR;
            else if (syscall_i) cur.code = EXC_SYS;
            else if (break_i)   cur.code = EXC_BP;
            else if (adel_ls_i) begin cur.code = EXC_ADEL; cur.bad_addr = bad_data_addr_i; end
            else if (ades_i)    begin cur.code = EXC_ADES; cur.bad_addr = bad_data_addr_i; end
            else if (eret_i)    cur.code = EXC_ERET;
        end
    end

    exc_state_e  state_q, state_d;
    exc_info_t   info_q, info_d, src;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] excepttype_q, excepttype_d, inst_addr_q, inst_addr_d;
    logic [31:0] bad_addr_q, bad_addr_d, new_pc_q, new_pc_d;
    logic        ds_q, ds_d, flush_q, flush_d;
    logic        stall, go_issue;

    always_comb begin
        src          = (state_q == S_IDLE) ? cur : info_q;
        state_d      = state_q;
        info_d       = info_q;
        cnt_d        = cnt_q;
        excepttype_d = '0;
        inst_addr_d  = '0;
        ds_d         = 1'b0;
        bad_addr_d   = '0;
        flush_d      = 1'b0;
        new_pc_d     = new_pc_q;
        stall        = 1'b0;
        go_issue     = 1'b0;
        case (state_q)
            S_IDLE: if (cur.code != '0) begin
                stall  = 1'b1;
                info_d = cur;
                if (bus_busy_i) state_d  = S_WAIT_BUS;
                else            go_issue = 1'b1;
            end
            S_WAIT_BUS: begin
                stall = 1'b1;
                if (!bus_busy_i) go_issue = 1'b1;
            end
            S_ISSUE: begin
                if (FLUSH_CYCLES > 1) begin
                    state_d = S_FLUSH;
                    cnt_d   = 2'(FLUSH_INIT);
                    flush_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q - 2'd1;
                    flush_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (go_issue) begin
            state_d      = S_ISSUE;
            excepttype_d = src.code;
            inst_addr_d  = src.pc;
            ds_d         = src.ds;
            bad_addr_d   = src.bad_addr;
            flush_d      = 1'b1;
            new_pc_d     = (src.code == EXC_ERET) ? src.epc : EXC_VECTOR;
        end
        if (!flush_d) new_pc_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            info_q       <= '0;
            cnt_q        <= '0;
            excepttype_q <= '0;
            inst_addr_q  <= '0;
            ds_q         <= 1'b0;
            bad_addr_q   <= '0;
            flush_q      <= 1'b0;
            new_pc_q     <= '0;
        end else begin
            state_q      <= state_d;
            info_q       <= info_d;
            cnt_q        <= cnt_d;
            excepttype_q <= excepttype_d;
            inst_addr_q  <= inst_addr_d;
            ds_q         <= ds_d;
            bad_addr_q   <= bad_addr_d;
            flush_q      <= flush_d;
            new_pc_q     <= new_pc_d;
        end
    end

    assign excepttype_o        = excepttype_q;
    assign current_inst_addr_o = inst_addr_q;
    assign is_in_delayslot_o   = ds_q;
    assign bad_addr_o          = bad_addr_q;
    assign flush_o             = flush_q;
    assign new_pc_o            = new_pc_q;
    assign stall_req_o         = stall;

endmodule
